cache_assoc_wb: RTL
===================

// Module: cache_assoc_wb
// PURPOSE
// Parametrised L1 data cache between processor and main memory; successor to the fixed 8-line write-through cache.
// Configurable set count, associativity (1 or 2 ways, LRU replacement) and write policy (write-through or write-back with dirty bits).
// Same processor/memory handshake as the previous generation, so it drops into the existing CPU top level unchanged.
// PARAMETERS
// SETS        8   number of sets, power of two, >=2; INDEX_W = log2(SETS)
// WAYS        2   associativity, 1 or 2 only
// WRITE_BACK  1   1 = write-back/write-allocate with dirty bits; 0 = write-through/write-allocate
// ADDR_W      30  processor word-address width
// WORD_W      32  word width
// BLK_WORDS   4   words per block, power of two; OFF_W = log2(BLK_WORDS); BLK_W = WORD_W*BLK_WORDS
// PORTS
// clk          in   1                 clock, all state on rising edge
// proc_reset_n in   1                 synchronous active-low reset
// proc_read    in   1                 read request, held stable while proc_stall=1
// proc_write   in   1                 write request, held stable while proc_stall=1
// proc_addr    in   ADDR_W            word address: {tag, index[INDEX_W], offset[OFF_W]}
// proc_wdata   in   WORD_W            write data
// proc_rdata   out  WORD_W            read data, valid when proc_read=1 and proc_stall=0
// proc_stall   out  1                 combinational; 1 = request not complete
// mem_read     out  1                 block read request, registered
// mem_write    out  1                 block write request, registered
// mem_addr     out  ADDR_W-OFF_W      block address, registered
// mem_wdata    out  BLK_W             block write data, registered
// mem_rdata    in   BLK_W             block read data, valid with mem_ready
// mem_ready    in   1                 one-cycle completion pulse for current mem request
// BEHAVIOUR
// - Reset (proc_reset_n=0 at edge): all valid/dirty/LRU bits 0, state IDLE, mem_read/mem_write=0, mem_addr=0, mem_wdata=0; proc_stall=0, proc_rdata=0 while in IDLE with no request. Reset mid-miss aborts the transaction; memory must tolerate the dropped request.
// - Word w of a block occupies bits [WORD_W*w +: WORD_W]; offset selects w.
// - Line store per way: valid, dirty (WRITE_BACK=1 only), tag, BLK_W data. One LRU bit per set when WAYS=2 (points at way to evict).
// - proc_write has priority if both requests are high; proc_rdata=0 whenever not delivering read data.
// - States: IDLE, WB_WRITE (evict dirty victim), ALLOC (fetch block), WT_WRITE (write-through store).
// - IDLE read hit: proc_stall=0, proc_rdata from hit way same cycle; LRU <= other way. Zero-cycle latency.
// - IDLE write hit, WRITE_BACK=1: word merged, dirty<=1, LRU updated, proc_stall=0, no memory traffic.
// - IDLE write hit, WRITE_BACK=0: word merged, proc_stall=1, next edge -> WT_WRITE with mem_write=1, mem_addr={tag,index}, mem_wdata=merged block.
// - IDLE miss: victim = lowest invalid way, else LRU way. proc_stall=1. If victim valid&dirty -> WB_WRITE: mem_write=1, mem_addr={victim tag,index}, mem_wdata=victim block. Else -> ALLOC: mem_read=1, mem_addr=proc_addr[ADDR_W-1:OFF_W].
// - WB_WRITE: hold outputs until mem_ready; on mem_ready mem_write<=0, mem_read<=1, mem_addr<=fill address, -> ALLOC. Victim dirty cleared.
// - ALLOC: hold until mem_ready; then victim line <= {valid=1, tag, mem_rdata}, mem_read<=0, LRU <= other way.
//   read: proc_rdata = selected word of mem_rdata and proc_stall=0 in the mem_ready cycle, -> IDLE.
//   write, WRITE_BACK=1: merge proc_wdata, dirty<=1, proc_stall=0 in that cycle, -> IDLE.
//   write, WRITE_BACK=0: merge, proc_stall=1, -> WT_WRITE with mem_write=1, mem_wdata=merged block.
// - WT_WRITE: hold until mem_ready; then mem_write<=0, proc_stall=0 in that cycle, -> IDLE.
// - mem_read and mem_write never both 1; mem outputs change only on state transitions; mem_ready outside WB_WRITE/ALLOC/WT_WRITE is ignored.
// - WAYS=1: LRU logic absent, victim is way 0. WRITE_BACK=0: dirty bits tied 0, WB_WRITE unreachable.
// TESTING
// 1. Reset, read addr 0x10 -> stall, mem_read=1 mem_addr=0x4; mem_ready with rdata word0=0xAAAA0000 -> same cycle proc_rdata=0xAAAA0000, stall=0; re-read -> hit, no mem_read.
// 2. WRITE_BACK=1: write 0x12345678 to 0x11 (hit after fill) -> no stall, no mem_write; fill two more conflicting tags in same set -> first eviction issues mem_write mem_addr=0x4 with word1=0x12345678, then mem_read.
// 3. WAYS=2: load tags A,B to set 0, read A, then miss on C -> B evicted (LRU), A still hits.
// 4. WRITE_BACK=0: write hit 0xDEADBEEF to 0x13 -> stall, mem_write=1 with word3=0xDEADBEEF, held 5 cycles until mem_ready, stall drops that cycle.
// 5. Assert proc_reset_n=0 during ALLOC -> next edge mem_read=0, state IDLE, prior lines invalid (re-read misses).
// 6. proc_read=proc_write=1 on a hit -> write performed, proc_rdata=0.

Source files
------------

// File: rtl/cache_assoc_wb_if.sv
// Processor/memory bus of the set-associative L1 data cache.
// master : the environment (processor requests and memory responses)
// slave  : the cache (processor responses and memory requests)
// Signals:
//   proc_read/proc_write/proc_addr/proc_wdata  processor request
//   proc_rdata/proc_stall                      processor response
//   mem_read/mem_write/mem_addr/mem_wdata      block request to memory
//   mem_rdata/mem_ready                        block response from memory
interface cache_assoc_wb_if #(
   parameter int ADDR_W    = 30,
   parameter int WORD_W    = 32,
   parameter int BLK_WORDS = 4
);
   localparam int OFF_W = $clog2(BLK_WORDS);
   localparam int BLK_W = WORD_W * BLK_WORDS;

   logic                    proc_read;
   logic                    proc_write;
   logic [ADDR_W-1:0]       proc_addr;
   logic [WORD_W-1:0]       proc_wdata;
   logic [WORD_W-1:0]       proc_rdata;
   logic                    proc_stall;
   logic                    mem_read;
   logic                    mem_write;
   logic [ADDR_W-OFF_W-1:0] mem_addr;
   logic [BLK_W-1:0]        mem_wdata;
   logic [BLK_W-1:0]        mem_rdata;
   logic                    mem_ready;

   modport master (
      output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
   );

   modport slave (
      input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
      output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cache_assoc_wb.sv
// Parametrised L1 data cache: SETS sets, WAYS (1 or 2) ways with LRU
// replacement, write-through or write-back (dirty bits), write-allocate.
// Ports:
//   clk           clock, all state on rising edge
//   proc_reset_n  synchronous active-low reset
//   bus           cache_assoc_wb_if.slave (processor and memory handshakes)
// Read hits complete in the request cycle; misses fetch a block (after
// writing back a dirty victim); write-through stores wait for memory.
module cache_assoc_wb #(
   parameter int SETS       = 8,
   parameter int WAYS       = 2,
   parameter int WRITE_BACK = 1,
   parameter int ADDR_W     = 30,
   parameter int WORD_W     = 32,
   parameter int BLK_WORDS  = 4
) (
   input logic              clk,
   input logic              proc_reset_n,
   cache_assoc_wb_if.slave  bus
);
   localparam int INDEX_W = $clog2(SETS);
   localparam int OFF_W   = $clog2(BLK_WORDS);
   localparam int BLK_W   = WORD_W * BLK_WORDS;
   localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W;
   localparam int BADDR_W = ADDR_W - OFF_W;

   typedef enum logic [1:0] {IDLE, WB_WRITE, ALLOC, WT_WRITE} state_t;

   state_t               state_q, state_d;
   logic                 valid_q [WAYS][SETS];
   logic                 dirty_q [WAYS][SETS];
   logic [TAG_W-1:0]     tag_q   [WAYS][SETS];
   logic [BLK_W-1:0]     data_q  [WAYS][SETS];
   logic                 lru_q   [SETS];
   logic                 vict_q, vict_d;
   logic                 mem_read_q, mem_read_d;
   logic                 mem_write_q, mem_write_d;
   logic [BADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [BLK_W-1:0]     mem_wdata_q, mem_wdata_d;

   logic [INDEX_W-1:0]   idx;
   logic [OFF_W-1:0]     off;
   logic [TAG_W-1:0]     tag;
   logic [BADDR_W-1:0]   blk_addr;
   logic                 req, wr;
   logic [WAYS-1:0]      hit_w;
   logic                 hit, hit_way, victim;
   logic                 stall;
   logic [WORD_W-1:0]    rdata;
   logic                 line_we, line_way;
   logic [BLK_W-1:0]     line_data;
   logic                 dirty_we, dirty_val, lru_we;

   function automatic logic [WORD_W-1:0] get_word(input logic [BLK_W-1:0] blk,
                                                  input logic [OFF_W-1:0] o);
      return blk[WORD_W*o +: WORD_W];
   endfunction

   function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0] blk,
                                                 input logic [OFF_W-1:0] o,
                                                 input logic [WORD_W-1:0] w);
      logic [BLK_W-1:0] r;
      r = blk;
      r[WORD_W*o +: WORD_W] = w;
      return r;
   endfunction

   assign idx      = bus.proc_addr[OFF_W +: INDEX_W];
   assign off      = bus.proc_addr[OFF_W-1:0];
   assign tag      = bus.proc_addr[ADDR_W-1 -: TAG_W];
   assign blk_addr = bus.proc_addr[ADDR_W-1:OFF_W];
   assign req      = bus.proc_read | bus.proc_write;
   assign wr       = bus.proc_write;   // write wins when both are asserted

   always_comb begin
      hit_way = 1'b0;
      // Lowest invalid way is preferred; otherwise the LRU pointer names the victim.
      victim  = (WAYS == 2) ? lru_q[idx] : 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         hit_w[w] = valid_q[w][idx] && (tag_q[w][idx] == tag);
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (hit_w[w]) hit_way = w[0];
         if (!valid_q[w][idx]) victim = w[0];
      end
      hit = |hit_w;
   end

   always_comb begin
      state_d     = state_q;
      vict_d      = vict_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      stall       = 1'b0;
      rdata       = '0;
      line_we     = 1'b0;
      line_way    = hit_way;
      line_data   = '0;
      dirty_we    = 1'b0;
      dirty_val   = 1'b0;
      lru_we      = 1'b0;
      case (state_q)
         IDLE: begin
            if (req && hit) begin
               lru_we = 1'b1;
               if (wr) begin
                  line_we   = 1'b1;
                  line_data = put_word(data_q[hit_way][idx], off, bus.proc_wdata);
                  if (WRITE_BACK != 0) begin
                     dirty_we  = 1'b1;
                     dirty_val = 1'b1;
                  end else begin
                     stall       = 1'b1;
                     state_d     = WT_WRITE;
                     mem_write_d = 1'b1;
                     mem_addr_d  = blk_addr;
                     mem_wdata_d = line_data;
                  end
               end else begin
                  rdata = get_word(data_q[hit_way][idx], off);
               end
            end else if (req) begin
               stall  = 1'b1;
               vict_d = victim;
               if (WRITE_BACK != 0 && valid_q[victim][idx] && dirty_q[victim][idx]) begin
                  state_d     = WB_WRITE;
                  mem_write_d = 1'b1;
                  mem_addr_d  = {tag_q[victim][idx], idx};
                  mem_wdata_d = data_q[victim][idx];
               end else begin
                  state_d    = ALLOC;
                  mem_read_d = 1'b1;
                  mem_addr_d = blk_addr;
               end
            end
         end
         WB_WRITE: begin
            stall = 1'b1;
            if (bus.mem_ready) begin
               state_d     = ALLOC;
               mem_write_d = 1'b0;
               mem_read_d  = 1'b1;
               mem_addr_d  = blk_addr;
               line_way    = vict_q;
               dirty_we    = 1'b1;
            end
         end
         ALLOC: begin
            stall = 1'b1;
            if (bus.mem_ready) begin
               line_we    = 1'b1;
               line_way   = vict_q;
               line_data  = bus.mem_rdata;
               lru_we     = 1'b1;
               dirty_we   = 1'b1;
               mem_read_d = 1'b0;
               if (wr) begin
                  line_data = put_word(bus.mem_rdata, off, bus.proc_wdata);
                  if (WRITE_BACK != 0) begin
                     dirty_val = 1'b1;
                     stall     = 1'b0;
                     state_d   = IDLE;
                  end else begin
                     state_d     = WT_WRITE;
                     mem_write_d = 1'b1;
                     mem_wdata_d = line_data;
                  end
               end else begin
                  rdata   = get_word(bus.mem_rdata, off);
                  stall   = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         WT_WRITE: begin
            stall = 1'b1;
            if (bus.mem_ready) begin
               stall       = 1'b0;
               mem_write_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!proc_reset_n) begin
         state_q     <= IDLE;
         vict_q      <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         for (int w = 0; w < WAYS; w++) begin
            for (int s = 0; s < SETS; s++) begin
               valid_q[w][s] <= 1'b0;
               dirty_q[w][s] <= 1'b0;
            end
         end
         for (int s = 0; s < SETS; s++) lru_q[s] <= 1'b0;
      end else begin
         state_q     <= state_d;
         vict_q      <= vict_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if (line_we) valid_q[line_way][idx] <= 1'b1;
         if (WRITE_BACK != 0 && dirty_we) dirty_q[line_way][idx] <= dirty_val;
         if (WAYS == 2 && lru_we) lru_q[idx] <= ~line_way;
      end
   end

   // Tag and data storage is qualified by valid bits, so it carries no reset.
   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_q[line_way][idx]  <= tag;
         data_q[line_way][idx] <= line_data;
      end
   end

   assign bus.proc_stall = stall;
   assign bus.proc_rdata = rdata;
   assign bus.mem_read   = mem_read_q;
   assign bus.mem_write  = mem_write_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
endmodule
